// File: rtl/ldst_reservation_station_pkg.sv
// Shared constants and entry layout for the load/store reservation station.
package ldst_reservation_station_pkg;

    localparam int unsigned DATA_LEN        = 32;
    localparam int unsigned RRF_SEL         = 6;
    localparam int unsigned RS_LDST_ENT_NUM = 4;
    localparam int unsigned RS_LDST_ENT_SEL = 2;

    typedef struct packed {
        logic                valid;
        logic [DATA_LEN-1:0] src1;
        logic                src1_ready;
        logic [DATA_LEN-1:0] src2;
        logic                src2_ready;
        logic [DATA_LEN-1:0] imm;
        logic [RRF_SEL-1:0]  rrf_tag;
        logic                if_write_rrf;
    } rs_ldst_entry_t;

endpackage

// File: rtl/ldst_reservation_station_operand_capture.sv
// Per-operand wakeup: captures broadcast data when a not-ready operand's tag hits a bus.
module rs_ldst_operand_capture
    import ldst_reservation_station_pkg::*;
(
    input  logic [DATA_LEN-1:0] i_src,
    input  logic                i_ready,
    input  logic                i_wb1_valid,
    input  logic [RRF_SEL-1:0]  i_wb1_tag,
    input  logic [DATA_LEN-1:0] i_wb1_data,
    input  logic                i_wb2_valid,
    input  logic [RRF_SEL-1:0]  i_wb2_tag,
    input  logic [DATA_LEN-1:0] i_wb2_data,
    output logic [DATA_LEN-1:0] o_src_c,
    output logic                o_ready_c
);

    logic w_hit1;
    logic w_hit2;

    assign w_hit1 = i_wb1_valid && (i_src[RRF_SEL-1:0] == i_wb1_tag);
    assign w_hit2 = i_wb2_valid && (i_src[RRF_SEL-1:0] == i_wb2_tag);

    // wb1 has priority when both buses carry the same tag
    always_comb begin
        o_src_c   = i_src;
        o_ready_c = i_ready;
        if (!i_ready) begin
            if (w_hit1) begin
                o_src_c   = i_wb1_data;
                o_ready_c = 1'b1;
            end else if (w_hit2) begin
                o_src_c   = i_wb2_data;
                o_ready_c = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ldst_reservation_station.sv
// In-order load/store reservation station: circular buffer, operand wakeup, head-only issue.
module ldst_reservation_station
    import ldst_reservation_station_pkg::*;
#(
    parameter int unsigned ENTRY_NUM = RS_LDST_ENT_NUM,
    parameter int unsigned ENTRY_SEL = RS_LDST_ENT_SEL
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                flush_i,
    input  logic                dispatch_i,
    input  logic [DATA_LEN-1:0] dp_src1_i,
    input  logic                dp_src1_ready_i,
    input  logic [DATA_LEN-1:0] dp_src2_i,
    input  logic                dp_src2_ready_i,
    input  logic [DATA_LEN-1:0] dp_imm_i,
    input  logic [RRF_SEL-1:0]  dp_rrf_tag_i,
    input  logic                dp_if_write_rrf_i,
    input  logic                wb1_valid_i,
    input  logic [RRF_SEL-1:0]  wb1_tag_i,
    input  logic [DATA_LEN-1:0] wb1_data_i,
    input  logic                wb2_valid_i,
    input  logic [RRF_SEL-1:0]  wb2_tag_i,
    input  logic [DATA_LEN-1:0] wb2_data_i,
    output logic                full_o,
    output logic                issue_o,
    output logic [DATA_LEN-1:0] src1_o,
    output logic [DATA_LEN-1:0] src2_o,
    output logic [DATA_LEN-1:0] imm_o,
    output logic [RRF_SEL-1:0]  rrf_tag_o,
    output logic                if_write_rrf_o
);

    localparam int unsigned CNT_W = ENTRY_SEL + 1;

    rs_ldst_entry_t       r_ent [ENTRY_NUM];
    logic [ENTRY_SEL-1:0] r_head;
    logic [ENTRY_SEL-1:0] r_tail;
    logic [CNT_W-1:0]     r_count;

    logic [DATA_LEN-1:0]  w_ent_src1     [ENTRY_NUM];
    logic                 w_ent_src1_rdy [ENTRY_NUM];
    logic [DATA_LEN-1:0]  w_ent_src2     [ENTRY_NUM];
    logic                 w_ent_src2_rdy [ENTRY_NUM];
    logic [DATA_LEN-1:0]  w_dp_src1;
    logic                 w_dp_src1_rdy;
    logic [DATA_LEN-1:0]  w_dp_src2;
    logic                 w_dp_src2_rdy;
    rs_ldst_entry_t       w_dp_entry;
    rs_ldst_entry_t       w_head;
    logic                 w_dispatch;

    for (genvar g = 0; g < ENTRY_NUM; g++) begin : g_ent
        rs_ldst_operand_capture u_cap_src1 (
            .i_src       (r_ent[g].src1),
            .i_ready     (r_ent[g].src1_ready),
            .i_wb1_valid (wb1_valid_i),
            .i_wb1_tag   (wb1_tag_i),
            .i_wb1_data  (wb1_data_i),
            .i_wb2_valid (wb2_valid_i),
            .i_wb2_tag   (wb2_tag_i),
            .i_wb2_data  (wb2_data_i),
            .o_src_c     (w_ent_src1[g]),
            .o_ready_c   (w_ent_src1_rdy[g])
        );
        rs_ldst_operand_capture u_cap_src2 (
            .i_src       (r_ent[g].src2),
            .i_ready     (r_ent[g].src2_ready),
            .i_wb1_valid (wb1_valid_i),
            .i_wb1_tag   (wb1_tag_i),
            .i_wb1_data  (wb1_data_i),
            .i_wb2_valid (wb2_valid_i),
            .i_wb2_tag   (wb2_tag_i),
            .i_wb2_data  (wb2_data_i),
            .o_src_c     (w_ent_src2[g]),
            .o_ready_c   (w_ent_src2_rdy[g])
        );
    end

    // Dispatch bypass: operands arriving with a same-cycle broadcast are stored ready
    rs_ldst_operand_capture u_dp_src1 (
        .i_src       (dp_src1_i),
        .i_ready     (dp_src1_ready_i),
        .i_wb1_valid (wb1_valid_i),
        .i_wb1_tag   (wb1_tag_i),
        .i_wb1_data  (wb1_data_i),
        .i_wb2_valid (wb2_valid_i),
        .i_wb2_tag   (wb2_tag_i),
        .i_wb2_data  (wb2_data_i),
        .o_src_c     (w_dp_src1),
        .o_ready_c   (w_dp_src1_rdy)
    );
    rs_ldst_operand_capture u_dp_src2 (
        .i_src       (dp_src2_i),
        .i_ready     (dp_src2_ready_i),
        .i_wb1_valid (wb1_valid_i),
        .i_wb1_tag   (wb1_tag_i),
        .i_wb1_data  (wb1_data_i),
        .i_wb2_valid (wb2_valid_i),
        .i_wb2_tag   (wb2_tag_i),
        .i_wb2_data  (wb2_data_i),
        .o_src_c     (w_dp_src2),
        .o_ready_c   (w_dp_src2_rdy)
    );

    always_comb begin
        w_dp_entry              = '0;
        w_dp_entry.valid        = 1'b1;
        w_dp_entry.src1         = w_dp_src1;
        w_dp_entry.src1_ready   = w_dp_src1_rdy;
        w_dp_entry.src2         = w_dp_src2;
        w_dp_entry.src2_ready   = w_dp_src2_rdy;
        w_dp_entry.imm          = dp_imm_i;
        w_dp_entry.rrf_tag      = dp_rrf_tag_i;
        w_dp_entry.if_write_rrf = dp_if_write_rrf_i;
    end

    assign w_head         = r_ent[r_head];
    assign full_o         = (r_count == CNT_W'(ENTRY_NUM));
    assign w_dispatch     = dispatch_i && !full_o && !flush_i;
    assign issue_o        = w_head.valid && w_head.src1_ready && w_head.src2_ready && !flush_i;
    assign src1_o         = w_head.src1;
    assign src2_o         = w_head.src2;
    assign imm_o          = w_head.imm;
    assign rrf_tag_o      = w_head.rrf_tag;
    assign if_write_rrf_o = w_head.if_write_rrf;

    always_ff @(posedge clk_i) begin
        if (reset_i || flush_i) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int unsigned i = 0; i < ENTRY_NUM; i++) begin
                r_ent[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < ENTRY_NUM; i++) begin
                if (r_ent[i].valid) begin
                    r_ent[i].src1       <= w_ent_src1[i];
                    r_ent[i].src1_ready <= w_ent_src1_rdy[i];
                    r_ent[i].src2       <= w_ent_src2[i];
                    r_ent[i].src2_ready <= w_ent_src2_rdy[i];
                end
            end
            // Head and tail never alias here: issue needs a valid head, dispatch needs a non-full queue
            if (issue_o) begin
                r_ent[r_head].valid <= 1'b0;
                r_head              <= r_head + ENTRY_SEL'(1);
            end
            if (w_dispatch) begin
                r_ent[r_tail] <= w_dp_entry;
                r_tail        <= r_tail + ENTRY_SEL'(1);
            end
            if (w_dispatch && !issue_o) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_dispatch && issue_o) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_ldst_reservation_station.sv
// Directed bench for ldst_reservation_station with an in-order issue scoreboard.
module tb_ldst_reservation_station;
    import ldst_reservation_station_pkg::*;

    logic                clk_i = 1'b0;
    logic                reset_i;
    logic                flush_i;
    logic                dispatch_i;
    logic [DATA_LEN-1:0] dp_src1_i;
    logic                dp_src1_ready_i;
    logic [DATA_LEN-1:0] dp_src2_i;
    logic                dp_src2_ready_i;
    logic [DATA_LEN-1:0] dp_imm_i;
    logic [RRF_SEL-1:0]  dp_rrf_tag_i;
    logic                dp_if_write_rrf_i;
    logic                wb1_valid_i;
    logic [RRF_SEL-1:0]  wb1_tag_i;
    logic [DATA_LEN-1:0] wb1_data_i;
    logic                wb2_valid_i;
    logic [RRF_SEL-1:0]  wb2_tag_i;
    logic [DATA_LEN-1:0] wb2_data_i;
    logic                full_o;
    logic                issue_o;
    logic [DATA_LEN-1:0] src1_o;
    logic [DATA_LEN-1:0] src2_o;
    logic [DATA_LEN-1:0] imm_o;
    logic [RRF_SEL-1:0]  rrf_tag_o;
    logic                if_write_rrf_o;

    typedef struct packed {
        logic [DATA_LEN-1:0] s1;
        logic [DATA_LEN-1:0] s2;
        logic [DATA_LEN-1:0] imm;
        logic [RRF_SEL-1:0]  tag;
        logic                wr;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    ldst_reservation_station dut (
        .clk_i            (clk_i),
        .reset_i          (reset_i),
        .flush_i          (flush_i),
        .dispatch_i       (dispatch_i),
        .dp_src1_i        (dp_src1_i),
        .dp_src1_ready_i  (dp_src1_ready_i),
        .dp_src2_i        (dp_src2_i),
        .dp_src2_ready_i  (dp_src2_ready_i),
        .dp_imm_i         (dp_imm_i),
        .dp_rrf_tag_i     (dp_rrf_tag_i),
        .dp_if_write_rrf_i(dp_if_write_rrf_i),
        .wb1_valid_i      (wb1_valid_i),
        .wb1_tag_i        (wb1_tag_i),
        .wb1_data_i       (wb1_data_i),
        .wb2_valid_i      (wb2_valid_i),
        .wb2_tag_i        (wb2_tag_i),
        .wb2_data_i       (wb2_data_i),
        .full_o           (full_o),
        .issue_o          (issue_o),
        .src1_o           (src1_o),
        .src2_o           (src2_o),
        .imm_o            (imm_o),
        .rrf_tag_o        (rrf_tag_o),
        .if_write_rrf_o   (if_write_rrf_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [DATA_LEN-1:0] obs, input logic [DATA_LEN-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        flush_i     = 1'b0;
        dispatch_i  = 1'b0;
        wb1_valid_i = 1'b0;
        wb2_valid_i = 1'b0;
    endtask

    task automatic dp(input logic [DATA_LEN-1:0] s1, input logic r1, input logic [DATA_LEN-1:0] s2,
                      input logic r2, input logic [DATA_LEN-1:0] imm, input logic [RRF_SEL-1:0] tag,
                      input logic wr);
        dispatch_i        = 1'b1;
        dp_src1_i         = s1;
        dp_src1_ready_i   = r1;
        dp_src2_i         = s2;
        dp_src2_ready_i   = r2;
        dp_imm_i          = imm;
        dp_rrf_tag_i      = tag;
        dp_if_write_rrf_i = wr;
    endtask

    task automatic push(input logic [DATA_LEN-1:0] s1, input logic [DATA_LEN-1:0] s2,
                        input logic [DATA_LEN-1:0] imm, input logic [RRF_SEL-1:0] tag, input logic wr);
        exp_t e;
        e.s1 = s1; e.s2 = s2; e.imm = imm; e.tag = tag; e.wr = wr;
        exp_q.push_back(e);
    endtask

    task automatic wb1(input logic [RRF_SEL-1:0] tag, input logic [DATA_LEN-1:0] data);
        wb1_valid_i = 1'b1; wb1_tag_i = tag; wb1_data_i = data;
    endtask

    task automatic wb2(input logic [RRF_SEL-1:0] tag, input logic [DATA_LEN-1:0] data);
        wb2_valid_i = 1'b1; wb2_tag_i = tag; wb2_data_i = data;
    endtask

    // Sample mid-cycle, pop/compare on issue, then commit the edge and drop one-shot inputs
    task automatic cyc(input string tag, input logic exp_issue, input logic exp_full);
        exp_t e;
        @(negedge clk_i);
        chk({tag, ".issue"}, DATA_LEN'(issue_o), DATA_LEN'(exp_issue));
        chk({tag, ".full"},  DATA_LEN'(full_o),  DATA_LEN'(exp_full));
        if (exp_issue && issue_o) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $error("FAIL %s.sb: observed issue expected empty scoreboard", tag);
            end else begin
                e = exp_q.pop_front();
                chk({tag, ".src1"}, src1_o, e.s1);
                chk({tag, ".src2"}, src2_o, e.s2);
                chk({tag, ".imm"},  imm_o,  e.imm);
                chk({tag, ".tag"},  DATA_LEN'(rrf_tag_o), DATA_LEN'(e.tag));
                chk({tag, ".wr"},   DATA_LEN'(if_write_rrf_o), DATA_LEN'(e.wr));
            end
        end
        @(posedge clk_i);
        #1;
        clear_inputs();
    endtask

    initial begin
        reset_i = 1'b1;
        clear_inputs();
        dp(0, 0, 0, 0, 0, 0, 0);
        dispatch_i = 1'b0;
        wb1_tag_i = '0; wb1_data_i = '0; wb2_tag_i = '0; wb2_data_i = '0;
        repeat (2) @(posedge clk_i);
        #1;
        reset_i = 1'b0;
        cyc("reset", 1'b0, 1'b0);

        // Ready load issues the cycle after dispatch
        dp(32'h100, 1, 32'h0, 1, 32'h4, 6'd1, 1);
        push(32'h100, 32'h0, 32'h4, 6'd1, 1);
        cyc("ld_dp", 0, 0);
        cyc("ld_iss", 1, 0);
        cyc("ld_idle", 0, 0);

        // Store waits for src2 tag 5 from wb2
        dp(32'h200, 1, 32'd5, 0, 32'h8, 6'd2, 0);
        push(32'h200, 32'hDEAD, 32'h8, 6'd2, 0);
        cyc("st_dp", 0, 0);
        cyc("st_wait", 0, 0);
        wb2(6'd5, 32'hDEAD);
        cyc("st_wb", 0, 0);
        cyc("st_iss", 1, 0);

        // Blocked head holds back a ready younger entry
        dp(32'd3, 0, 32'h11, 1, 32'h0, 6'd3, 1);
        push(32'hAAAA, 32'h11, 32'h0, 6'd3, 1);
        cyc("ord_dpA", 0, 0);
        dp(32'h300, 1, 32'h22, 1, 32'hC, 6'd4, 1);
        push(32'h300, 32'h22, 32'hC, 6'd4, 1);
        cyc("ord_dpB", 0, 0);
        cyc("ord_hold1", 0, 0);
        cyc("ord_hold2", 0, 0);
        wb1(6'd3, 32'hAAAA);
        cyc("ord_wb", 0, 0);
        cyc("ord_issA", 1, 0);
        cyc("ord_issB", 1, 0);
        cyc("ord_idle", 0, 0);

        // Fill, reject while full, reject during issue, accept next cycle; pointers wrap
        dp(32'd9, 0, 32'h40, 1, 32'h10, 6'h10, 1);
        push(32'h99, 32'h40, 32'h10, 6'h10, 1);
        cyc("fill0", 0, 0);
        for (int i = 1; i < 4; i++) begin
            dp(32'h400 + 32'(i), 1, 32'h40 + 32'(i), 1, 32'h10 + 32'(i), 6'(6'h10 + i), i[0]);
            push(32'h400 + 32'(i), 32'h40 + 32'(i), 32'h10 + 32'(i), 6'(6'h10 + i), i[0]);
            cyc("fill", 0, 0);
        end
        dp(32'hBAD, 1, 32'hBAD, 1, 32'hBAD, 6'h3F, 1);
        cyc("full_drop", 0, 1);
        wb1(6'd9, 32'h99);
        cyc("full_wb", 0, 1);
        dp(32'hE0, 1, 32'hE1, 1, 32'hE, 6'h1E, 0);
        cyc("full_iss_rej", 1, 1);
        dp(32'hE0, 1, 32'hE1, 1, 32'hE, 6'h1E, 0);
        push(32'hE0, 32'hE1, 32'hE, 6'h1E, 0);
        cyc("wrap_acc", 1, 0);
        cyc("drain2", 1, 0);
        cyc("drain3", 1, 0);
        cyc("drainE", 1, 0);
        cyc("drain_idle", 0, 0);

        // Dispatch bypass from a same-cycle broadcast
        dp(32'd7, 0, 32'h66, 1, 32'h70, 6'h27, 1);
        wb1(6'd7, 32'h55);
        push(32'h55, 32'h66, 32'h70, 6'h27, 1);
        cyc("byp_dp", 0, 0);
        cyc("byp_iss", 1, 0);

        // Same tag on both buses: wb1 wins
        dp(32'h500, 1, 32'h10, 0, 32'h5, 6'h2A, 0);
        push(32'h500, 32'h1111, 32'h5, 6'h2A, 0);
        cyc("pri_dp", 0, 0);
        wb1(6'h10, 32'h1111);
        wb2(6'h10, 32'h2222);
        cyc("pri_wb", 0, 0);
        cyc("pri_iss", 1, 0);

        // Flush with three entries plus a concurrent dispatch
        for (int i = 0; i < 3; i++) begin
            dp(32'h20, 0, 32'h0, 1, 32'(i), 6'(i), 1);
            cyc("fl_dp", 0, 0);
        end
        dp(32'h600, 1, 32'h601, 1, 32'h602, 6'h30, 1);
        flush_i = 1'b1;
        cyc("fl_flush", 0, 0);
        cyc("fl_after", 0, 0);
        wb1(6'h20, 32'h777);
        cyc("fl_wb", 0, 0);
        cyc("fl_quiet", 0, 0);
        for (int i = 0; i < 4; i++) begin
            dp(32'h21, 0, 32'h0, 1, 32'(i), 6'(i), 0);
            cyc("fl_refill", 0, 0);
        end
        cyc("fl_full", 0, 1);
        flush_i = 1'b1;
        cyc("fl_flush2", 0, 1);
        cyc("fl_empty", 0, 0);

        chk("sb_drain", DATA_LEN'(exp_q.size()), '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
